// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtraction controller.
package serial_sub_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/serial_sub_ctrl_fs_bit.sv
// One-bit full-subtractor cell: d = a - b - bi, bo is the borrow out.
module fs_bit (
    input  logic a,
    input  logic b,
    input  logic bi,
    output logic d,
    output logic bo
);

    assign d  = a ^ b ^ bi;
    assign bo = (~a & b) | (~(a ^ b) & bi);

endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial a - b (- bin) controller driving a single fs_bit cell LSB-first.
// Optional initial borrow input enabled by SERIAL_SUB_BORROW_IN_EN.
module serial_sub_ctrl
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SERIAL_SUB_BORROW_IN_EN
    input  logic             bin,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output state_e           state_o
);

    localparam int CW = $clog2(WIDTH + 1);

    // Handshake: start is a level request sampled only in IDLE; done is a
    // single-cycle pulse with diff/bout valid from that cycle until the next done.
    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, diff_q, diff_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             brw_q, brw_d, bout_q, bout_d;
    logic             init_borrow;
    logic             cell_d, cell_bo;

`ifdef SERIAL_SUB_BORROW_IN_EN
    assign init_borrow = bin;
`else
    assign init_borrow = 1'b0;
`endif

    fs_bit u_cell (
        .a  (a_q[0]),
        .b  (b_q[0]),
        .bi (brw_q),
        .d  (cell_d),
        .bo (cell_bo)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            diff_q  <= '0;
            cnt_q   <= '0;
            brw_q   <= 1'b0;
            bout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            diff_q  <= diff_d;
            cnt_q   <= cnt_d;
            brw_q   <= brw_d;
            bout_q  <= bout_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        diff_d  = diff_q;
        cnt_d   = cnt_q;
        brw_d   = brw_q;
        bout_d  = bout_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SHIFT;
                    a_d     = a;
                    b_d     = b;
                    cnt_d   = '0;
                    brw_d   = init_borrow;
                end
            end
            SHIFT: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                res_d = {cell_d, res_q[WIDTH-1:1]};
                brw_d = cell_bo;
                cnt_d = cnt_q + CW'(1);
                // The last bit is folded into the published result on this same edge.
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = DONE;
                    diff_d  = {cell_d, res_q[WIDTH-1:1]};
                    bout_d  = cell_bo;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign busy    = (state_q == SHIFT);
    assign done    = (state_q == DONE);
    assign diff    = diff_q;
    assign bout    = bout_q;
    assign state_o = state_q;

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Scoreboard bench for serial_sub_ctrl: WIDTH=8 directed/random plus WIDTH=2 exhaustive.
module tb_serial_sub_ctrl;
  import serial_sub_pkg::*;

  localparam int W8 = 8;
  localparam int W2 = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          start = 1'b0;
  logic [W8-1:0] a = '0, b = '0;
  logic          bin = 1'b0;
  logic          busy, done, bout;
  logic [W8-1:0] diff;
  state_e        st;

  logic          start2 = 1'b0;
  logic [W2-1:0] a2 = '0, b2 = '0;
  logic          bin2 = 1'b0;
  logic          busy2, done2, bout2;
  logic [W2-1:0] diff2;
  state_e        st2;

  serial_sub_ctrl #(.WIDTH(W8)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
`ifdef SERIAL_SUB_BORROW_IN_EN
    .bin(bin),
`endif
    .busy(busy), .done(done), .diff(diff), .bout(bout), .state_o(st)
  );

  serial_sub_ctrl #(.WIDTH(W2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2),
`ifdef SERIAL_SUB_BORROW_IN_EN
    .bin(bin2),
`endif
    .busy(busy2), .done(done2), .diff(diff2), .bout(bout2), .state_o(st2)
  );

  int checks = 0;
  int errors = 0;
  logic [W8:0] exp_q[$];
  logic [W2:0] exp2_q[$];

  // Reference: plain integer subtraction, result modulo 2^w, borrow when a < b + bin.
  function automatic logic [32:0] ref_sub(input int w, input int av, input int bv, input int bi);
    longint m, r;
    logic [32:0] res;
    m = longint'(1) << w;
    r = (longint'(av) - longint'(bv) - longint'(bi)) % m;
    if (r < 0) r = r + m;
    res = '0;
    res[31:0] = 32'(r);
    res[w] = (av < bv + bi);
    return res;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && done) begin
      logic [W8:0] e;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL w8_unexpected_done: got diff=0x%0h bout=%0b expected no done", diff, bout);
      end else begin
        e = exp_q.pop_front();
        if ({bout, diff} !== e) begin
          errors++;
          $display("FAIL w8_result: got bout=%0b diff=0x%0h expected bout=%0b diff=0x%0h",
                   bout, diff, e[W8], e[W8-1:0]);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && done2) begin
      logic [W2:0] e;
      checks++;
      if (exp2_q.size() == 0) begin
        errors++;
        $display("FAIL w2_unexpected_done: got diff=0x%0h bout=%0b expected no done", diff2, bout2);
      end else begin
        e = exp2_q.pop_front();
        if ({bout2, diff2} !== e) begin
          errors++;
          $display("FAIL w2_result: got bout=%0b diff=0x%0h expected bout=%0b diff=0x%0h",
                   bout2, diff2, e[W2], e[W2-1:0]);
        end
      end
    end
  end

  task automatic op8(input logic [W8-1:0] av, input logic [W8-1:0] bv, input logic bi, input bit mid);
    int  busy_cnt, lat;
    bit  got;
    logic [32:0] r;
    logic        bi_eff;
`ifdef SERIAL_SUB_BORROW_IN_EN
    bi_eff = bi;
`else
    bi_eff = 1'b0;
`endif
    @(negedge clk);
    a = av; b = bv; bin = bi; start = 1'b1;
    r = ref_sub(W8, int'(av), int'(bv), int'(bi_eff));
    exp_q.push_back({r[W8], r[W8-1:0]});
    @(posedge clk);
    #1;
    start = 1'b0;
    a = W8'($urandom_range(0, 255));
    b = W8'($urandom_range(0, 255));
    bin = 1'($urandom_range(0, 1));
    busy_cnt = 0; got = 1'b0; lat = 0;
    for (int c = 0; c < W8 + 4 && !got; c++) begin
      @(negedge clk);
      if (mid && c == 3) begin a = 8'hAA; b = 8'h55; start = 1'b1; end
      if (mid && c == 4) start = 1'b0;
      if (done) begin got = 1'b1; lat = c; end
      else if (busy) busy_cnt++;
    end
    chk("done_seen", 32'(got), 32'd1);
    chk("done_latency", 32'(lat), 32'(W8));
    chk("busy_cycles", 32'(busy_cnt), 32'(W8));
    @(negedge clk);
    chk("done_single_pulse", 32'(done), 32'd0);
    chk("back_to_idle", 32'(st), 32'(IDLE));
  endtask

  task automatic op2(input logic [W2-1:0] av, input logic [W2-1:0] bv);
    bit got;
    logic [32:0] r;
    @(negedge clk);
    a2 = av; b2 = bv; start2 = 1'b1;
    r = ref_sub(W2, int'(av), int'(bv), 0);
    exp2_q.push_back({r[W2], r[W2-1:0]});
    @(posedge clk);
    #1;
    start2 = 1'b0;
    got = 1'b0;
    for (int c = 0; c < W2 + 4 && !got; c++) begin
      @(negedge clk);
      if (done2) got = 1'b1;
    end
    chk("w2_done_seen", 32'(got), 32'd1);
  endtask

  initial begin
    #3;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_diff", 32'(diff), 32'd0);
    chk("rst_bout", 32'(bout), 32'd0);
    chk("rst_state", 32'(st), 32'(IDLE));
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;

    op8(8'h05, 8'h03, 1'b0, 1'b0);
    op8(8'h03, 8'h05, 1'b0, 1'b0);
    op8(8'h00, 8'h01, 1'b0, 1'b0);
    op8(8'hFF, 8'hFF, 1'b0, 1'b0);
    op8(8'h05, 8'h03, 1'b0, 1'b1);

    // Abort an operation four cycles in; its result must never appear.
    @(negedge clk);
    a = 8'h37; b = 8'h12; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_diff", 32'(diff), 32'd0);
    chk("abort_bout", 32'(bout), 32'd0);
    chk("abort_state", 32'(st), 32'(IDLE));
    @(posedge clk);
    #3 rst = 1'b0;
    op8(8'h10, 8'h01, 1'b0, 1'b0);

`ifdef SERIAL_SUB_BORROW_IN_EN
    op8(8'h05, 8'h03, 1'b1, 1'b0);
    op8(8'h00, 8'h00, 1'b1, 1'b0);
`endif

    for (int i = 0; i < 25; i++)
      op8(W8'($urandom_range(0, 255)), W8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'b0);

    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        op2(W2'(i), W2'(j));

    repeat (3) @(negedge clk);
    chk("w8_queue_drained", 32'(exp_q.size()), 32'd0);
    chk("w2_queue_drained", 32'(exp2_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
